// File: rtl/pipe_reg_dump_if.sv
// pipe_reg_dump_if
//  Valid/ready stream carrying one captured register per word.
//  master : valid, idx, data, last driven; ready sampled
//  slave  : valid, idx, data, last sampled; ready driven
interface pipe_reg_dump_if #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output idx, output data, output last, input ready);
  modport slave  (input valid, input idx, input data, input last, output ready);
endinterface

// File: rtl/pipe_reg_dump.sv
// pipe_reg_dump
//  Debug-side reader for the CPU register-inspection port. On i_start it walks
//  o_reg_sel over an inclusive (wrapping) index range, lets the combinational
//  register-file read settle for SETTLE cycles, captures i_reg_data and emits
//  the value as one word on the o_stream valid/ready interface.
// Ports
//  clk, rst     : clock (rising edge), asynchronous active-high reset
//  i_start      : begin a scan (only honoured while idle)
//  i_first_sel  : first register index, latched with an accepted start
//  i_last_sel   : last register index (inclusive), latched with an accepted start
//  i_abort      : cancel a scan in progress, no done pulse
//  o_busy       : scan in progress
//  o_done       : one-cycle pulse after the final word transfers
//  o_reg_sel    : register index toward the CPU debug port
//  i_reg_data   : register value from the CPU debug port (combinational)
//  o_stream     : output word stream (valid/ready/idx/data/last)
module pipe_reg_dump #(
  parameter int NREGS  = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [SEL_W-1:0]  i_first_sel,
  input  logic [SEL_W-1:0]  i_last_sel,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [SEL_W-1:0]  o_reg_sel,
  input  logic [DATA_W-1:0] i_reg_data,
  pipe_reg_dump_if.master   o_stream
);

  localparam int               CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NREGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD, S_DONE} state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_last_sel;
  logic [SEL_W-1:0]  r_reg_sel;   // doubles as the current scan index
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_last;
  logic [SEL_W-1:0]  r_out_idx;
  logic [DATA_W-1:0] r_out_data;

  logic              w_xfer;
  logic [SEL_W-1:0]  w_next_sel;

  assign w_xfer = r_valid & o_stream.ready;
  // Explicit wrap so NREGS need not be a power of two.
  assign w_next_sel = (r_reg_sel == SEL_MAX) ? '0 : r_reg_sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_sel <= '0;
      r_reg_sel  <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_out_idx  <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_last_sel <= i_last_sel;
            r_reg_sel  <= i_first_sel;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (i_abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_END) begin
            // reg_data is only looked at on this edge; earlier glitches are ignored.
            r_out_data <= i_reg_data;
            r_out_idx  <= r_reg_sel;
            r_last     <= (r_reg_sel == r_last_sel);
            r_valid    <= 1'b1;
            r_state    <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          // Abort outranks the final transfer: the word may still go out
          // on this edge, but no done pulse follows.
          if (i_abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_xfer) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_reg_sel <= w_next_sel;
              r_cnt     <= '0;
              r_state   <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_reg_sel     = r_reg_sel;
  assign o_stream.valid = r_valid;
  assign o_stream.idx   = r_out_idx;
  assign o_stream.data  = r_out_data;
  assign o_stream.last  = r_last;

endmodule

// File: tb/tb_pipe_reg_dump.sv
module tb_pipe_reg_dump;
  localparam int NREGS  = 32;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 32;
  localparam int SETTLE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SEL_W-1:0]  first_sel = '0;
  logic [SEL_W-1:0]  last_sel = '0;
  logic              busy;
  logic              done;
  logic [SEL_W-1:0]  reg_sel;
  logic [DATA_W-1:0] reg_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_reg_dump_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) s_if ();

  // Register file model: the read path lags reg_sel by one cycle, so a
  // sample taken too early would see the previous register.
  logic [DATA_W-1:0] regs [NREGS];
  logic [SEL_W-1:0]  sel_q = '0;
  always @(posedge clk) sel_q <= reg_sel;
  assign reg_data = regs[sel_q];

  pipe_reg_dump #(
    .NREGS (NREGS),
    .SEL_W (SEL_W),
    .DATA_W(DATA_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_first_sel(first_sel),
    .i_last_sel (last_sel),
    .i_abort    (abort),
    .o_busy     (busy),
    .o_done     (done),
    .o_reg_sel  (reg_sel),
    .i_reg_data (reg_data),
    .o_stream   (s_if.master)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
  endtask

  // One scan, checked against the word list derived from the range rules.
  // abort_word >= 0 holds that word with ready=0 for two cycles then aborts.
  task automatic run_scan(input logic [SEL_W-1:0] f, input logic [SEL_W-1:0] l,
                          input int ready_pct, input int bp_cycles, input int abort_word);
    int n, k, low, hold, cyc;
    bit fin, rdy;
    logic [SEL_W-1:0] exp_idx;
    n = ((int'(l) - int'(f) + NREGS) % NREGS) + 1;
    first_sel = f;
    last_sel  = l;
    start     = 1'b1;
    s_if.ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0; low = 0; hold = 0; cyc = 0; fin = 0;
    while (!fin) begin
      cyc++;
      if (cyc > 4000) begin
        chk("scan_timeout", 64'(cyc), 0);
        fin = 1;
      end else begin
        exp_idx = SEL_W'((int'(f) + k) % NREGS);
        if (s_if.valid) begin
          if (hold == 0) chk("settle_gap", 64'(low), 64'(SETTLE));
          chk("out_idx", s_if.idx, exp_idx);
          chk("out_data", s_if.data, regs[exp_idx]);
          chk("out_last", s_if.last, (k == n - 1));
          chk("busy_hold", busy, 1);
          low = 0;
          if (abort_word == k && hold >= 2) begin
            abort = 1'b1;
            s_if.ready = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_valid", s_if.valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            $display("abort at word %0d idx=%0d", k, exp_idx);
            @(negedge clk);
            chk("abort_nodone", done, 0);
            fin = 1;
          end else begin
            rdy = (hold < bp_cycles || abort_word == k) ? 1'b0
                  : ($urandom_range(99) < ready_pct);
            s_if.ready = rdy;
            if (rdy) begin
              $display("word idx=%0d data=%08h last=%0d", exp_idx, s_if.data, s_if.last);
              hold = 0;
              k++;
              if (k == n) begin
                @(negedge clk);
                s_if.ready = 1'b0;
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_valid", s_if.valid, 0);
                // start during the DONE cycle must not launch a scan
                first_sel = f + 1'b1;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("done_clear", done, 0);
                chk("idle_busy", busy, 0);
                @(negedge clk);
                chk("start_in_done_ignored", busy, 0);
                chk("reg_sel_holds", reg_sel, l);
                fin = 1;
              end
            end else begin
              hold++;
            end
          end
        end else begin
          chk("sel_track", reg_sel, exp_idx);
          chk("done_early", done, 0);
          low++;
        end
        if (!fin) @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = i * 32'h1111_1111;
    s_if.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", s_if.valid, 0);
    chk("rst_sel", reg_sel, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy0", busy, 0);

    run_scan(5'd0, 5'd31, 100, 0, -1);   // full scan
    run_scan(5'd5, 5'd5, 100, 10, -1);   // single word, backpressure
    for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
    run_scan(5'd30, 5'd1, 60, 0, -1);    // wrap
    run_scan(5'd10, 5'd20, 100, 0, 2);   // abort on third word
    run_scan(5'd0, 5'd0, 100, 0, -1);    // restart after abort

    // async reset mid-HOLD, between edges
    first_sel = 5'd4; last_sel = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && !s_if.valid; c++) @(negedge clk);
    chk("pre_rst_valid", s_if.valid, 1);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", s_if.valid, 0);
    chk("arst_last", s_if.last, 0);
    chk("arst_idx", s_if.idx, 0);
    chk("arst_data", s_if.data, 0);
    chk("arst_sel", reg_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("arst_start_ignored", busy, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      run_scan(SEL_W'($urandom_range(NREGS - 1)), SEL_W'($urandom_range(NREGS - 1)),
               $urandom_range(100, 30), 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
